// File: rtl/ifetch_ctrl_if.sv
// Bundle of the fetch controller's PC, instruction-memory, redirect and
// decode-side signals. The master modport is the controller's view; the
// slave modport is the view of the surrounding PC/memory/decode logic.
interface ifetch_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // PC register controls
  logic [ADDR_W-1:0] pc_q;
  logic              pc_en;
  logic              pc_aload;
  logic [ADDR_W-1:0] pc_d;
  // Instruction memory req/ack port
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // Branch redirect
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  // Decode valid/ready port
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;

  modport master (
    input  pc_q, mem_ack, mem_rdata, br_valid, br_target, ir_ready,
    output pc_en, pc_aload, pc_d, mem_req, mem_addr, ir_valid, ir_data, ir_pc
  );

  modport slave (
    output pc_q, mem_ack, mem_rdata, br_valid, br_target, ir_ready,
    input  pc_en, pc_aload, pc_d, mem_req, mem_addr, ir_valid, ir_data, ir_pc
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller. Reads the PC, issues one req/ack read at a
// time to instruction memory, and presents the fetched word to decode.
// Branch redirects load the PC and squash any wrong-path read or beat.
//
// Handshakes:
//   memory : mem_req rises and stays high with mem_addr stable until the
//            cycle mem_ack=1; that cycle completes the read and mem_rdata
//            is valid. Only reset may drop mem_req without an ack.
//   decode : ir_valid/ir_data/ir_pc hold until a cycle with ir_valid=1 and
//            ir_ready=1; that cycle transfers the beat, except when
//            br_valid=1, which squashes it and decode must ignore it.
module ifetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ifetch_ctrl_if.master         bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              ir_valid_q;
  logic              kill_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] ir_pc_q;
  logic [DATA_W-1:0] ir_data_q;

  logic              ack_ok;
  logic              pc_en_c;
  logic              pc_aload_c;

  // PC strobes: a redirect always loads; an accepted (non-squashed) ack
  // increments. Both are forced low while reset is asserted.
  always_comb begin
    pc_aload_c = rst & bus.br_valid;
    ack_ok     = (state_q == S_FETCH) & bus.mem_ack & ~kill_q & ~bus.br_valid;
    pc_en_c    = rst & ack_ok;
  end

  // Fetch address follows the PC's next value whenever no read is in
  // flight, so it already reflects an increment or redirect happening now.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (state_q != S_FETCH) begin
      if (pc_aload_c) begin
        fetch_pc_d = bus.br_target;
      end else if (pc_en_c) begin
        fetch_pc_d = bus.pc_q + ADDR_W'(1);
      end else begin
        fetch_pc_d = bus.pc_q;
      end
    end
  end

  // Fetch FSM with registered mem_req / ir_valid and the instruction latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      kill_q     <= 1'b0;
      fetch_pc_q <= '0;
      ir_pc_q    <= '0;
      ir_data_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      case (state_q)
        S_IDLE: begin
          state_q   <= S_FETCH;
          mem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            kill_q    <= 1'b0;
            mem_req_q <= 1'b0;
            if (ack_ok) begin
              ir_data_q  <= bus.mem_rdata;
              ir_pc_q    <= fetch_pc_q;
              ir_valid_q <= 1'b1;
              state_q    <= S_OUT;
            end else begin
              // Wrong-path data: spend one cycle with mem_req low so the
              // fetch address can pick up the redirected PC, then refetch.
              state_q <= S_IDLE;
            end
          end else if (bus.br_valid) begin
            // The read cannot be withdrawn; remember to drop its data.
            kill_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.ir_ready || bus.br_valid) begin
            ir_valid_q <= 1'b0;
            mem_req_q  <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          mem_req_q  <= 1'b0;
          ir_valid_q <= 1'b0;
          kill_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_en    = pc_en_c;
  assign bus.pc_aload = pc_aload_c;
  assign bus.pc_d     = bus.br_target;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = fetch_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.ir_data  = ir_data_q;
  assign bus.ir_pc    = ir_pc_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: PC register model, instruction memory
// with programmable wait states (data = addr ^ A5A5), a decode-side
// scoreboard of expected {ir_pc, ir_data} beats, and a final report.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state;

  ifetch_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  ifetch_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [15:0] pc;
  logic        pc_set_en;
  logic [15:0] pc_set_val;
  logic [3:0]  req_cnt;
  logic [3:0]  wait_n;

  always @(posedge clk) begin
    if (pc_set_en)         pc <= pc_set_val;
    else if (bus.pc_aload) pc <= bus.pc_d;
    else if (bus.pc_en)    pc <= pc + 16'd1;
  end

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) req_cnt <= 4'd0;
    else                             req_cnt <= req_cnt + 4'd1;
  end

  assign bus.pc_q      = pc;
  assign bus.mem_ack   = bus.mem_req && (req_cnt == wait_n);
  assign bus.mem_rdata = bus.mem_addr ^ 16'hA5A5;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int extra_beats = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Accepted decode beats are compared in order against exp_q.
  always @(negedge clk) begin
    if (rst && bus.ir_valid && bus.ir_ready && !bus.br_valid) begin
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("beat_pc",   {16'h0, bus.ir_pc},   {16'h0, e[31:16]});
        chk("beat_data", {16'h0, bus.ir_data}, {16'h0, e[15:0]});
      end else begin
        extra_beats++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk_fetch(input logic [15:0] a, input logic ack, input logic en);
    chk("fetch_req",   {31'h0, bus.mem_req},  32'd1);
    chk("fetch_addr",  {16'h0, bus.mem_addr}, {16'h0, a});
    chk("fetch_ack",   {31'h0, bus.mem_ack},  {31'h0, ack});
    chk("fetch_pc_en", {31'h0, bus.pc_en},    {31'h0, en});
    chk("fetch_irv",   {31'h0, bus.ir_valid}, 32'd0);
  endtask

  task automatic chk_out(input logic [15:0] p, input logic [15:0] d);
    chk("out_valid", {31'h0, bus.ir_valid}, 32'd1);
    chk("out_pc",    {16'h0, bus.ir_pc},    {16'h0, p});
    chk("out_data",  {16'h0, bus.ir_data},  {16'h0, d});
    chk("out_req",   {31'h0, bus.mem_req},  32'd0);
    chk("out_pc_en", {31'h0, bus.pc_en},    32'd0);
  endtask

  task automatic chk_gap();
    chk("gap_req",   {31'h0, bus.mem_req},  32'd0);
    chk("gap_irv",   {31'h0, bus.ir_valid}, 32'd0);
    chk("gap_pc_en", {31'h0, bus.pc_en},    32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] beat_data [4];

  initial begin
    beat_data[0] = 16'hA5A5; beat_data[1] = 16'hA5A4;
    beat_data[2] = 16'hA5A7; beat_data[3] = 16'hA5A6;
    rst = 1'b0; bus.br_valid = 1'b0; bus.br_target = 16'h0; bus.ir_ready = 1'b1;
    wait_n = 4'd0; pc_set_en = 1'b1; pc_set_val = 16'h0000;

    // Reset state
    drv(); drv(); nxt();
    chk("rst_state",  {30'h0, dbg_state},    32'd0);
    chk("rst_req",    {31'h0, bus.mem_req},  32'd0);
    chk("rst_irv",    {31'h0, bus.ir_valid}, 32'd0);
    chk("rst_ir_data",{16'h0, bus.ir_data},  32'd0);
    chk("rst_ir_pc",  {16'h0, bus.ir_pc},    32'd0);
    chk("rst_addr",   {16'h0, bus.mem_addr}, 32'd0);
    chk("rst_pc_en",  {31'h0, bus.pc_en},    32'd0);

    // Stream with zero-wait memory
    for (int b = 0; b < 4; b++) exp_q.push_back({16'(b), beat_data[b]});
    exp_q.push_back({16'h0004, 16'hA5A1});
    drv(); rst = 1'b1; pc_set_en = 1'b0;
    nxt();
    chk("idle_state", {30'h0, dbg_state},   32'd0);
    chk("idle_req",   {31'h0, bus.mem_req}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      nxt(); chk_fetch(16'(b), 1'b1, 1'b1);
      nxt(); chk_out(16'(b), beat_data[b]);
    end

    // Backpressure: beat 4 held for 5 cycles
    drv(); bus.ir_ready = 1'b0;
    nxt(); chk_fetch(16'h0004, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      nxt(); chk_out(16'h0004, 16'hA5A1);
    end
    drv(); bus.ir_ready = 1'b1; wait_n = 4'd3;
    nxt(); chk_out(16'h0004, 16'hA5A1);

    // Wait states: ack 3 cycles after req
    exp_q.push_back({16'h0005, 16'hA5A0});
    for (int i = 0; i < 3; i++) begin
      nxt(); chk_fetch(16'h0005, 1'b0, 1'b0);
    end
    nxt(); chk_fetch(16'h0005, 1'b1, 1'b1);
    nxt(); chk_out(16'h0005, 16'hA5A0);

    // Branch while read outstanding
    nxt(); chk_fetch(16'h0006, 1'b0, 1'b0);
    drv(); bus.br_valid = 1'b1; bus.br_target = 16'h0040;
    nxt(); chk_fetch(16'h0006, 1'b0, 1'b0);
    chk("mid_aload", {31'h0, bus.pc_aload}, 32'd1);
    chk("mid_pc_d",  {16'h0, bus.pc_d},     32'h0040);
    drv(); bus.br_valid = 1'b0;
    nxt(); chk_fetch(16'h0006, 1'b0, 1'b0);
    chk("mid_aload_off", {31'h0, bus.pc_aload}, 32'd0);
    nxt(); chk_fetch(16'h0006, 1'b1, 1'b0);
    drv(); wait_n = 4'd0;
    nxt(); chk_gap();
    chk("mid_pc_loaded", {16'h0, pc}, 32'h0040);
    exp_q.push_back({16'h0040, 16'hA5E5});
    nxt(); chk_fetch(16'h0040, 1'b1, 1'b1);
    nxt(); chk_out(16'h0040, 16'hA5E5);

    // Branch coincident with ack
    drv(); bus.br_valid = 1'b1; bus.br_target = 16'h0080;
    nxt(); chk_fetch(16'h0041, 1'b1, 1'b0);
    chk("ack_br_aload", {31'h0, bus.pc_aload}, 32'd1);
    drv(); bus.br_valid = 1'b0;
    nxt(); chk_gap();
    nxt(); chk_fetch(16'h0080, 1'b1, 1'b1);

    // Branch coincident with ir_ready: beat 0x80 squashed
    drv(); bus.br_valid = 1'b1; bus.br_target = 16'h0100;
    nxt();
    chk("rdy_br_irv",   {31'h0, bus.ir_valid}, 32'd1);
    chk("rdy_br_pc",    {16'h0, bus.ir_pc},    32'h0080);
    chk("rdy_br_pc_en", {31'h0, bus.pc_en},    32'd0);
    chk("rdy_br_aload", {31'h0, bus.pc_aload}, 32'd1);
    drv(); bus.br_valid = 1'b0;
    exp_q.push_back({16'h0100, 16'hA4A5});
    nxt(); chk_fetch(16'h0100, 1'b1, 1'b1);
    nxt(); chk_out(16'h0100, 16'hA4A5);

    // Reset with PC preset to FFFF; pc_en gated even though ack is high
    drv(); rst = 1'b0; pc_set_en = 1'b1; pc_set_val = 16'hFFFF;
    nxt();
    chk("rst_ack_seen", {31'h0, bus.mem_ack}, 32'd1);
    chk("rst_pc_en_gated", {31'h0, bus.pc_en}, 32'd0);
    drv(); rst = 1'b1; pc_set_en = 1'b0;
    nxt();
    chk("rst2_state", {30'h0, dbg_state},    32'd0);
    chk("rst2_req",   {31'h0, bus.mem_req},  32'd0);
    chk("rst2_ir_pc", {16'h0, bus.ir_pc},    32'd0);
    chk("rst2_data",  {16'h0, bus.ir_data},  32'd0);
    exp_q.push_back({16'hFFFF, 16'h5A5A});
    nxt(); chk_fetch(16'hFFFF, 1'b1, 1'b1);
    drv(); wait_n = 4'd3;
    nxt(); chk_out(16'hFFFF, 16'h5A5A);
    chk("wrap_pc", {16'h0, pc}, 32'h0000);
    nxt(); chk_fetch(16'h0000, 1'b0, 1'b0);

    // Reset during an outstanding read
    drv(); rst = 1'b0; bus.br_valid = 1'b1; bus.br_target = 16'h1234;
    nxt();
    chk("rstrd_aload", {31'h0, bus.pc_aload}, 32'd0);
    chk("rstrd_pc_en", {31'h0, bus.pc_en},    32'd0);
    chk("rstrd_req_before", {31'h0, bus.mem_req}, 32'd1);
    drv(); bus.br_valid = 1'b0;
    nxt();
    chk("rstrd_req",   {31'h0, bus.mem_req},  32'd0);
    chk("rstrd_irv",   {31'h0, bus.ir_valid}, 32'd0);
    chk("rstrd_state", {30'h0, dbg_state},    32'd0);
    drv(); rst = 1'b1;
    repeat (3) nxt();

    // Final report
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("extra_beats", extra_beats,   32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
